// File: rtl/pkt_demux.sv
// rtl/pkt_demux.sv - registered 1-to-N packet demultiplexer
//
// Routes each whole packet from one valid/ready input stream to the output
// port named by s_sel on the packet's first beat. One output register stage.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   s_valid/s_ready       input beat handshake
//   s_data, s_last        input beat data and end-of-packet flag
//   s_sel                 destination, sampled on the first beat only
//   m_valid[N_OUT]        per-output valid, at most one bit set
//   m_ready[N_OUT]        per-output ready
//   m_data, m_last        shared output beat, meaningful where m_valid is set
//   busy                  a packet is open (first beat taken, last not yet)
//   cur_dest              locked destination of the open packet
//   sel_err               one-cycle pulse after a first beat with s_sel >= N_OUT
//
// Parameters: DATA_W beat width, N_OUT ports (2..16), SEL_W with 2**SEL_W >= N_OUT.

module pkt_demux #(
  parameter int DATA_W = 8,
  parameter int N_OUT  = 4,
  parameter int SEL_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  input  logic [SEL_W-1:0]  s_sel,
  output logic [N_OUT-1:0]  m_valid,
  input  logic [N_OUT-1:0]  m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic [SEL_W-1:0]  cur_dest,
  output logic              sel_err
);

  typedef enum logic {
    IDLE  = 1'b0,
    ROUTE = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    cur_dest_q, cur_dest_d;
  logic                ovalid_q, ovalid_d;
  logic [SEL_W-1:0]    odest_q, odest_d;
  logic [DATA_W-1:0]   odata_q, odata_d;
  logic                olast_q, olast_d;
  logic                sel_err_q, sel_err_d;

  logic                sel_ready;
  logic                first_beat;
  logic [SEL_W-1:0]    dest_in;
  logic                drop;
  logic                accept;

  // Ready of the port currently held in the output register; other ports'
  // ready bits never influence the handshake.
  always_comb begin
    sel_ready = 1'b0;
    for (int i = 0; i < N_OUT; i++) begin
      if (int'(odest_q) == i) sel_ready = m_ready[i];
    end
  end

  assign first_beat = (state_q == IDLE);
  assign dest_in    = first_beat ? s_sel : cur_dest_q;
  // Beats headed for a non-existent port are swallowed without touching the
  // output register, so they must not wait on it either.
  assign drop       = (int'(dest_in) >= N_OUT);
  assign s_ready    = drop || !ovalid_q || sel_ready;
  assign accept     = s_valid && s_ready;

  always_comb begin
    state_d    = state_q;
    cur_dest_d = cur_dest_q;
    ovalid_d   = ovalid_q;
    odest_d    = odest_q;
    odata_d    = odata_q;
    olast_d    = olast_q;
    sel_err_d  = 1'b0;

    if (ovalid_q && sel_ready) ovalid_d = 1'b0;

    // A load in the same cycle as a drain overrides the clear above, which
    // gives one beat per cycle and no bubble between packets.
    if (accept) begin
      if (!drop) begin
        ovalid_d = 1'b1;
        odest_d  = dest_in;
        odata_d  = s_data;
        olast_d  = s_last;
      end
      if (first_beat) begin
        sel_err_d = drop;
        if (!s_last) begin
          state_d    = ROUTE;
          cur_dest_d = s_sel;
        end
      end else if (s_last) begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cur_dest_q <= '0;
      ovalid_q   <= 1'b0;
      odest_q    <= '0;
      odata_q    <= '0;
      olast_q    <= 1'b0;
      sel_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_dest_q <= cur_dest_d;
      ovalid_q   <= ovalid_d;
      odest_q    <= odest_d;
      odata_q    <= odata_d;
      olast_q    <= olast_d;
      sel_err_q  <= sel_err_d;
    end
  end

  always_comb begin
    m_valid = '0;
    for (int i = 0; i < N_OUT; i++) begin
      m_valid[i] = ovalid_q && (int'(odest_q) == i);
    end
  end

  assign m_data   = odata_q;
  assign m_last   = olast_q;
  assign busy     = (state_q == ROUTE);
  assign cur_dest = cur_dest_q;
  assign sel_err  = sel_err_q;

  a_onehot_valid : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(m_valid));

  // Inside a packet the beat goes to the locked port whatever s_sel says.
  a_locked_dest : assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == ROUTE && accept && !drop) |=> (odest_q == $past(cur_dest_q)));

endmodule
